// File: rtl/regfile_dump_streamer.sv
// Walks a register-file address range and streams each word, tagged with its index, on a valid/ready port.
// Define REGFILE_DUMP_CHECKSUM_EN to append one XOR-checksum beat after the register beats.
module regfile_dump_streamer #(
  parameter int N = 32,
  parameter int A = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [A-1:0] first_addr,
  input  logic [A-1:0] last_addr,
  output logic         busy,
  output logic         done,
  output logic [A-1:0] rf_rd_addr,
  input  logic [N-1:0] rf_rd_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [A-1:0] out_addr,
  output logic         out_last
);

`ifdef REGFILE_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND, S_CSUM, S_DONE} state_t;
  logic [N-1:0] csum_q, csum_d;
`else
  typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_t;
`endif

  state_t       state_q, state_d;
  logic [A-1:0] end_q, end_d;
  logic [A-1:0] rf_rd_addr_q, rf_rd_addr_d;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_data_q, out_data_d;
  logic [A-1:0] out_addr_q, out_addr_d;
  logic         out_last_q, out_last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      end_q        <= '0;
      rf_rd_addr_q <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_addr_q   <= '0;
      out_last_q   <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      end_q        <= end_d;
      rf_rd_addr_q <= rf_rd_addr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_addr_q   <= out_addr_d;
      out_last_q   <= out_last_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    end_d        = end_q;
    rf_rd_addr_d = rf_rd_addr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_addr_d   = out_addr_q;
    out_last_d   = out_last_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          end_d        = last_addr;
          rf_rd_addr_d = first_addr;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          csum_d       = '0;
`endif
          state_d      = S_READ;
        end
      end
      S_READ: begin
        out_data_d  = rf_rd_data;
        out_addr_d  = rf_rd_addr_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
`else
        out_last_d  = (rf_rd_addr_q == end_q);
`endif
        out_valid_d = 1'b1;
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          csum_d      = csum_q ^ out_data_q;
`endif
          if (rf_rd_addr_q == end_q) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else begin
            // Address arithmetic is modulo 2^A so a range can wrap through 0.
            rf_rd_addr_d = rf_rd_addr_q + A'(1);
            state_d      = S_READ;
          end
        end
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      S_CSUM: begin
        // First cycle loads the checksum beat; afterwards wait for its handshake.
        if (!out_valid_q) begin
          out_data_d  = csum_q;
          out_addr_d  = '0;
          out_last_d  = 1'b1;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_DONE;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign rf_rd_addr = rf_rd_addr_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_addr   = out_addr_q;
  assign out_last   = out_last_q;

endmodule
